// File: rtl/jk_bank_scheduler_pkg.sv
// Shared op codes, FSM states and J/K decode helpers for the JK bank scheduler.
package jk_bank_scheduler_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SETUP   = 2'b01,
        ST_FIRE    = 2'b10,
        ST_RELEASE = 2'b11
    } state_t;

    // J is asserted for SET and TOGGLE
    function automatic logic op_j(input op_t op);
        return (op == OP_SET) || (op == OP_TOGGLE);
    endfunction

    // K is asserted for RESET and TOGGLE
    function automatic logic op_k(input op_t op);
        return (op == OP_RESET) || (op == OP_TOGGLE);
    endfunction

endpackage

// File: rtl/jk_bank_scheduler_cell.sv
// Single clocked JK storage cell with synchronous reset and update enable.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    input  logic en,
    output logic q
);

    // JK update only on enable; reset has priority so an aborted op never lands
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (en) begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_scheduler.sv
// Two-requester round-robin scheduler sequencing ops onto a bank of JK cells.
module jk_bank_scheduler
    import jk_bank_scheduler_pkg::*;
#(
    parameter  int N_CELLS      = 8,
    parameter  int SETUP_CYCLES = 1,
    localparam int AW           = (N_CELLS > 1) ? $clog2(N_CELLS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic [1:0]         op0,
    input  logic [1:0]         op1,
    input  logic [AW-1:0]      addr0,
    input  logic [AW-1:0]      addr1,
    output logic [1:0]         gnt,
    output logic [1:0]         done,
    output logic               busy,
    output logic [N_CELLS-1:0] cell_en,
    output logic [N_CELLS-1:0] q
);

    localparam int CW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          ptr;
    logic          pick;
    logic          winner;
    op_t           op_r;
    logic [AW-1:0] addr_r;
    logic [1:0]    win_onehot;
    logic          drive;
    logic          j, k;

    // Round-robin pick: a lone requester wins, a tie goes to the pointer owner
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ptr;
            default: pick = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // FSM next-state
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (|req) state_nx = ST_SETUP;
            ST_SETUP:   if (cnt == SETUP_LAST) state_nx = ST_FIRE;
            ST_FIRE:    state_nx = ST_RELEASE;
            ST_RELEASE: state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Capture winner/op/addr at grant, advance pointer, count setup cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            ptr    <= 1'b0;
            winner <= 1'b0;
            op_r   <= OP_HOLD;
            addr_r <= '0;
        end else if (state == ST_IDLE && (|req)) begin
            cnt    <= '0;
            winner <= pick;
            ptr    <= ~pick;
            op_r   <= op_t'(pick ? op1 : op0);
            addr_r <= pick ? addr1 : addr0;
        end else if (state == ST_SETUP) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Handshake outputs and J/K/enable decode; out-of-range addresses match no cell
    always_comb begin
        win_onehot = winner ? 2'b10 : 2'b01;
        gnt        = (state == ST_SETUP && cnt == '0) ? win_onehot : '0;
        done       = (state == ST_RELEASE) ? win_onehot : '0;
        busy       = (state != ST_IDLE);
        drive      = (state == ST_SETUP) || (state == ST_FIRE);
        j          = drive && op_j(op_r);
        k          = drive && op_k(op_r);
        cell_en    = '0;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            cell_en[i] = (state == ST_FIRE) && (addr_r == AW'(i));
        end
    end

    for (genvar g = 0; g < N_CELLS; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j),
            .k     (k),
            .en    (cell_en[g]),
            .q     (q[g])
        );
    end

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Directed self-checking bench for jk_bank_scheduler (6 cells, 1 setup cycle).
module tb_jk_bank_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] op0, op1;
    logic [2:0] addr0, addr1;
    logic [1:0] gnt, done;
    logic       busy;
    logic [5:0] cell_en, q;

    int checks   = 0;
    int failures = 0;

    jk_bank_scheduler #(.N_CELLS(6), .SETUP_CYCLES(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .op0     (op0),
        .op1     (op1),
        .addr0   (addr0),
        .addr1   (addr1),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .cell_en (cell_en),
        .q       (q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One uncontended op from IDLE; returns to IDLE at the end
    task automatic single(input string tag, input int w, input logic [1:0] op,
                          input logic [2:0] addr, input logic [5:0] exp_en,
                          input logic [5:0] exp_q);
        logic [1:0] r;
        r = (w == 1) ? 2'b10 : 2'b01;
        if (w == 1) begin op1 = op; addr1 = addr; end
        else        begin op0 = op; addr0 = addr; end
        req = r;
        tick();
        chk({tag, "_gnt"}, gnt, r);
        chk({tag, "_busy"}, busy, 1'b1);
        req = 2'b00;
        tick();
        chk({tag, "_en"}, cell_en, exp_en);
        chk({tag, "_gnt0"}, gnt, 2'b00);
        tick();
        chk({tag, "_q"}, q, exp_q);
        chk({tag, "_done"}, done, r);
        chk({tag, "_en0"}, cell_en, 6'h00);
        tick();
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_done0"}, done, 2'b00);
    endtask

    initial begin
        reset = 1'b1; req = 2'b11;
        op0 = 2'b10; op1 = 2'b11; addr0 = 3'd1; addr1 = 3'd2;

        // Reset held two cycles with both requests high
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_gnt", gnt, 2'b00);
            chk("rst_done", done, 2'b00);
            chk("rst_busy", busy, 1'b0);
            chk("rst_q", q, 6'h00);
            chk("rst_en", cell_en, 6'h00);
        end
        reset = 1'b0; req = 2'b00;
        tick();
        chk("post_rst_busy", busy, 1'b0);

        // SET cell 3 from requester 0
        single("set3", 0, 2'b10, 3'd3, 6'h08, 6'h08);

        // TOGGLE cell 5 twice from requester 1 (second one wins alone against the pointer)
        single("tog5a", 1, 2'b11, 3'd5, 6'h20, 6'h28);
        single("tog5b", 1, 2'b11, 3'd5, 6'h20, 6'h08);

        // Contention: both held, grants must alternate, none while busy
        op0 = 2'b10; addr0 = 3'd0;
        op1 = 2'b10; addr1 = 3'd1;
        req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            logic [1:0] ew;
            ew = (n % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            chk("rr_gnt", gnt, ew);
            tick();
            chk("rr_en", cell_en, (n % 2 == 0) ? 6'h01 : 6'h02);
            chk("rr_gnt_busy1", gnt, 2'b00);
            tick();
            chk("rr_done", done, ew);
            chk("rr_gnt_busy2", gnt, 2'b00);
            chk("rr_q", q, (n == 0) ? 6'h09 : 6'h0B);
            tick();
            chk("rr_idle", busy, 1'b0);
            chk("rr_gnt_idle", gnt, 2'b00);
            if (n == 3) req = 2'b00;
        end

        // Out-of-range address: handshake runs, no strobe, q untouched
        single("oor7", 0, 2'b10, 3'd7, 6'h00, 6'h0B);

        // HOLD strobes the cell but leaves it; RESET clears it
        single("hold4", 0, 2'b00, 3'd4, 6'h10, 6'h0B);
        single("rst3", 1, 2'b01, 3'd3, 6'h08, 6'h03);

        // Reset asserted in the FIRE cycle of a SET on cell 0
        op0 = 2'b10; addr0 = 3'd0; req = 2'b01;
        tick();
        chk("abort_gnt", gnt, 2'b01);
        req = 2'b00;
        tick();
        chk("abort_fire_en", cell_en, 6'h01);
        reset = 1'b1;
        tick();
        chk("abort_q", q, 6'h00);
        chk("abort_done", done, 2'b00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_en", cell_en, 6'h00);
        reset = 1'b0;
        tick();
        chk("abort_done_after", done, 2'b00);
        chk("abort_q_after", q, 6'h00);

        // Normal service resumes
        single("after_abort", 0, 2'b10, 3'd2, 6'h04, 6'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
